// File: rtl/lcd_ctrl.sv
// HD44780 write-only controller: buffers command/data bytes from the core in a small FIFO,
// runs the power-up init sequence, then replays each byte with setup/EN/hold/execution timing.
module lcd_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYC     = 2,
    parameter int EN_CYC        = 12,
    parameter int HOLD_CYC      = 2,
    parameter int CMD_WAIT_CYC  = 2000,
    parameter int CLR_WAIT_CYC  = 82000,
    parameter int INIT_WAIT_CYC = 750000
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_vld,
    input  logic       i_rs,
    input  logic [7:0] i_data,
    output logic       o_rdy,
    output logic       o_busy,
    output logic       o_init_done,
    output logic       o_lcd_on,
    output logic       o_lcd_en,
    output logic       o_lcd_rs,
    output logic       o_lcd_rw,
    output logic [7:0] o_lcd_data
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int MAX_CYC  = max2(max2(max2(SETUP_CYC, EN_CYC), max2(HOLD_CYC, CMD_WAIT_CYC)),
                                   max2(CLR_WAIT_CYC, INIT_WAIT_CYC));
    localparam int CNT_W    = $clog2(MAX_CYC) + 1;
    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int INIT_LEN = 6;

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t SETUP_LD = cnt_t'(SETUP_CYC - 1);
    localparam cnt_t EN_LD    = cnt_t'(EN_CYC - 1);
    localparam cnt_t HOLD_LD  = cnt_t'(HOLD_CYC - 1);
    localparam cnt_t CMD_LD   = cnt_t'(CMD_WAIT_CYC - 1);
    localparam cnt_t CLR_LD   = cnt_t'(CLR_WAIT_CYC - 1);
    localparam cnt_t INIT_LD  = cnt_t'(INIT_WAIT_CYC - 1);

    typedef enum logic [2:0] {
        ST_PWR_WAIT,
        ST_LOAD,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } state_t;

    // 8-bit interface, 2 lines, display on, clear, entry mode increment.
    function automatic logic [7:0] init_byte(input logic [2:0] idx);
        case (idx)
            3'd0, 3'd1, 3'd2: return 8'h38;
            3'd3:             return 8'h0C;
            3'd4:             return 8'h01;
            3'd5:             return 8'h06;
            default:          return 8'h00;
        endcase
    endfunction

    // FIFO storage and pointers
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, empty, push, pop;
    logic [8:0]       head;

    // Sequencer state and registered LCD outputs
    state_t     state_q, state_d;
    cnt_t       cnt_q, cnt_d;
    logic [2:0] init_idx_q, init_idx_d;
    logic       init_done_q, init_done_d;
    logic       lcd_on_q, lcd_on_d;
    logic       lcd_en_q, lcd_en_d;
    logic       lcd_rs_q, lcd_rs_d;
    logic [7:0] lcd_data_q, lcd_data_d;
    logic       is_clr;

    assign full  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign push  = i_vld && !full;
    assign pop   = (state_q == ST_LOAD) && init_done_q;
    assign head  = mem_q[rd_ptr_q];

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: the storage array carries no reset; the pointers and count define validity.
    always_ff @(posedge i_clk) begin
        if (push) mem_q[wr_ptr_q] <= {i_rs, i_data};
    end

    // Clear and return-home need the long execution wait.
    assign is_clr = !lcd_rs_q && (lcd_data_q >= 8'h01) && (lcd_data_q <= 8'h03);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_idx_d  = init_idx_q;
        init_done_d = init_done_q;
        lcd_on_d    = 1'b1;
        lcd_rs_d    = lcd_rs_q;
        lcd_data_d  = lcd_data_q;

        case (state_q)
            ST_PWR_WAIT: begin
                // lcd_on_q low marks the first cycle out of reset, where the wait is armed.
                if (!lcd_on_q)          cnt_d = INIT_LD;
                else if (cnt_q == '0)   state_d = ST_LOAD;
                else                    cnt_d = cnt_q - 1'b1;
            end
            ST_LOAD: begin
                if (!init_done_q) begin
                    lcd_rs_d   = 1'b0;
                    lcd_data_d = init_byte(init_idx_q);
                    init_idx_d = init_idx_q + 1'b1;
                end else begin
                    lcd_rs_d   = head[8];
                    lcd_data_d = head[7:0];
                end
                state_d = ST_SETUP;
                cnt_d   = SETUP_LD;
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_EN_HI;
                    cnt_d   = EN_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_EN_HI: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_WAIT;
                    cnt_d   = is_clr ? CLR_LD : CMD_LD;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!init_done_q) begin
                    if (init_idx_q == 3'(INIT_LEN)) begin
                        init_done_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = empty ? ST_IDLE : ST_LOAD;
                end
            end
            ST_IDLE: begin
                if (!empty) state_d = ST_LOAD;
            end
            default: state_d = ST_PWR_WAIT;
        endcase

        lcd_en_d = (state_d == ST_EN_HI);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= ST_PWR_WAIT;
            cnt_q       <= '0;
            init_idx_q  <= '0;
            init_done_q <= 1'b0;
            lcd_on_q    <= 1'b0;
            lcd_en_q    <= 1'b0;
            lcd_rs_q    <= 1'b0;
            lcd_data_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_idx_q  <= init_idx_d;
            init_done_q <= init_done_d;
            lcd_on_q    <= lcd_on_d;
            lcd_en_q    <= lcd_en_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_data_q  <= lcd_data_d;
        end
    end

    assign o_rdy       = !full;
    assign o_busy      = !empty || (state_q != ST_IDLE);
    assign o_init_done = init_done_q;
    assign o_lcd_on    = lcd_on_q;
    assign o_lcd_en    = lcd_en_q;
    assign o_lcd_rs    = lcd_rs_q;
    assign o_lcd_rw    = 1'b0;
    assign o_lcd_data  = lcd_data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with shortened timing; an EN monitor logs every pulse
// (rise edge, rs/data, width) and each scenario task compares the log against hand-derived values.
module tb_lcd_ctrl;

    localparam int INIT_W = 10;
    localparam int CMD_W  = 5;
    localparam int CLR_W  = 20;
    localparam int SETUP  = 2;
    localparam int EN_W   = 3;
    localparam int HOLD   = 2;
    localparam int DEPTH  = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       vld = 1'b0;
    logic       rs = 1'b0;
    logic [7:0] data = 8'h00;
    logic       o_rdy, o_busy, o_init_done, o_lcd_on, o_lcd_en, o_lcd_rs, o_lcd_rw;
    logic [7:0] o_lcd_data;

    lcd_ctrl #(
        .FIFO_DEPTH(DEPTH), .SETUP_CYC(SETUP), .EN_CYC(EN_W), .HOLD_CYC(HOLD),
        .CMD_WAIT_CYC(CMD_W), .CLR_WAIT_CYC(CLR_W), .INIT_WAIT_CYC(INIT_W)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_vld(vld), .i_rs(rs), .i_data(data),
        .o_rdy(o_rdy), .o_busy(o_busy), .o_init_done(o_init_done), .o_lcd_on(o_lcd_on),
        .o_lcd_en(o_lcd_en), .o_lcd_rs(o_lcd_rs), .o_lcd_rw(o_lcd_rw), .o_lcd_data(o_lcd_data)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rel_cyc = 0;

    logic [7:0] init_rom [6] = '{8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    int         init_gap [5] = '{13, 13, 13, 13, 28};
    localparam int FIRST_RISE = 1 + INIT_W + 1 + SETUP;

    int         rise_cyc [$];
    logic [8:0] rise_bus [$];
    int         widths   [$];
    logic       prev_en = 1'b0;
    int         cur_w = 0;
    logic [8:0] cur_bus = '0;
    bit         stable_bad = 0;
    bit         rw_bad = 0;

    // EN pulse logger, sampled 1 time unit after each rising edge
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (o_lcd_rw !== 1'b0) rw_bad = 1;
        if (o_lcd_en === 1'b1 && prev_en !== 1'b1) begin
            rise_cyc.push_back(cyc);
            rise_bus.push_back({o_lcd_rs, o_lcd_data});
            cur_w   = 1;
            cur_bus = {o_lcd_rs, o_lcd_data};
        end else if (o_lcd_en === 1'b1) begin
            cur_w = cur_w + 1;
            if ({o_lcd_rs, o_lcd_data} !== cur_bus) stable_bad = 1;
        end else if (prev_en === 1'b1) begin
            widths.push_back(cur_w);
        end
        prev_en = o_lcd_en;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, need finish");
        $fatal(1, "watchdog");
    end

    task automatic clear_mon();
        rise_cyc.delete();
        rise_bus.delete();
        widths.delete();
        stable_bad = 0;
    endtask

    task automatic drive(input logic r, input logic [7:0] d, output bit acc, output int edge_c);
        vld  = 1'b1;
        rs   = r;
        data = d;
        acc  = o_rdy;
        @(negedge clk);
        edge_c = cyc;
    endtask

    task automatic wait_done(input string name, input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (o_init_done === 1'b1) break;
        end
        n_tests++;
        if (k == max_cyc) begin
            n_fail++;
            $display("FAIL %s: init_done never rose within %0d cycles, need 1", name, max_cyc);
        end
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        int k;
        for (k = 0; k < max_cyc; k++) begin
            @(negedge clk);
            if (o_busy === 1'b0) break;
        end
        n_tests++;
        if (k == max_cyc) begin
            n_fail++;
            $display("FAIL %s: busy still high after %0d cycles, need 0", name, max_cyc);
        end
    endtask

    task automatic check_init_log(input string name, input int rel);
        n_tests++;
        if (rise_bus.size() < 6) begin
            n_fail++;
            $display("FAIL %s_count: got %0d EN pulses, need at least 6", name, rise_bus.size());
        end
        for (int i = 0; i < 6 && i < rise_bus.size(); i++) begin
            n_tests++;
            if (rise_bus[i] !== {1'b0, init_rom[i]}) begin
                n_fail++;
                $display("FAIL %s_byte%0d: got rs/data %h, need %h", name, i, rise_bus[i], {1'b0, init_rom[i]});
            end
        end
        for (int i = 0; i < 6 && i < widths.size(); i++) begin
            n_tests++;
            if (widths[i] !== EN_W) begin
                n_fail++;
                $display("FAIL %s_width%0d: got %0d, need %0d", name, i, widths[i], EN_W);
            end
        end
        for (int i = 0; i < 5 && i + 1 < rise_cyc.size(); i++) begin
            n_tests++;
            if (rise_cyc[i+1] - rise_cyc[i] !== init_gap[i]) begin
                n_fail++;
                $display("FAIL %s_gap%0d: got %0d, need %0d", name, i, rise_cyc[i+1] - rise_cyc[i], init_gap[i]);
            end
        end
        if (rise_cyc.size() > 0) begin
            n_tests++;
            if (rise_cyc[0] !== rel + FIRST_RISE) begin
                n_fail++;
                $display("FAIL %s_first_rise: got edge %0d, need %0d", name, rise_cyc[0], rel + FIRST_RISE);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_on, o_init_done, o_busy, o_rdy} !==
            {1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_outputs: got en=%b rs=%b rw=%b data=%h on=%b done=%b busy=%b rdy=%b, need 0 0 0 00 0 0 1 1",
                     o_lcd_en, o_lcd_rs, o_lcd_rw, o_lcd_data, o_lcd_on, o_init_done, o_busy, o_rdy);
        end
        rst_n   = 1'b1;
        rel_cyc = cyc;
        clear_mon();
        @(negedge clk);
        n_tests++;
        if ({o_lcd_on, o_busy, o_init_done, o_lcd_en} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_release: got on=%b busy=%b done=%b en=%b, need 1 1 0 0",
                     o_lcd_on, o_busy, o_init_done, o_lcd_en);
        end
    endtask

    task automatic test_init();
        int done_cyc;
        wait_done("init_wait", 300);
        done_cyc = cyc;
        check_init_log("init", rel_cyc);
        n_tests++;
        if (rise_cyc.size() == 6 && done_cyc !== rise_cyc[5] + EN_W + HOLD + CMD_W) begin
            n_fail++;
            $display("FAIL init_done_time: got edge %0d, need %0d", done_cyc, rise_cyc[5] + EN_W + HOLD + CMD_W);
        end
        n_tests++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL init_busy: got %b, need 0", o_busy);
        end
    endtask

    task automatic test_single();
        bit acc;
        int n;
        @(negedge clk);
        clear_mon();
        drive(1'b1, 8'h41, acc, n);
        vld = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            n_tests++;
            if (o_lcd_en !== (k >= 4 && k <= 6)) begin
                n_fail++;
                $display("FAIL single_en_k%0d: got %b, need %b", k, o_lcd_en, (k >= 4 && k <= 6));
            end
            if (k >= 2 && k <= 8) begin
                n_tests++;
                if ({o_lcd_rs, o_lcd_data} !== 9'h141) begin
                    n_fail++;
                    $display("FAIL single_bus_k%0d: got %h, need 141", k, {o_lcd_rs, o_lcd_data});
                end
            end
            n_tests++;
            if (o_busy !== (k < 14)) begin
                n_fail++;
                $display("FAIL single_busy_k%0d: got %b, need %b", k, o_busy, (k < 14));
            end
        end
        n_tests++;
        if (rise_cyc.size() != 1 || rise_cyc[0] !== n + 4 || widths[0] !== EN_W) begin
            n_fail++;
            $display("FAIL single_pulse: got %0d pulses, need 1 rising at edge %0d width %0d", rise_cyc.size(), n + 4, EN_W);
        end
    endtask

    task automatic test_clear_gap();
        bit acc;
        int n1, n2;
        @(negedge clk);
        clear_mon();
        drive(1'b0, 8'h01, acc, n1);
        drive(1'b1, 8'h42, acc, n2);
        vld = 1'b0;
        wait_idle("clear_idle", 200);
        n_tests++;
        if (rise_cyc.size() != 2) begin
            n_fail++;
            $display("FAIL clear_count: got %0d pulses, need 2", rise_cyc.size());
        end else begin
            n_tests++;
            if (rise_cyc[1] - rise_cyc[0] !== SETUP + EN_W + HOLD + CLR_W + 1) begin
                n_fail++;
                $display("FAIL clear_gap: got %0d, need %0d", rise_cyc[1] - rise_cyc[0], SETUP + EN_W + HOLD + CLR_W + 1);
            end
            n_tests++;
            if (rise_bus[0] !== 9'h001 || rise_bus[1] !== 9'h142 || rise_cyc[0] !== n1 + 4) begin
                n_fail++;
                $display("FAIL clear_bytes: got %h %h at edge %0d, need 001 142 at edge %0d",
                         rise_bus[0], rise_bus[1], rise_cyc[0], n1 + 4);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc;
        int n, e, refusals;
        @(negedge clk);
        clear_mon();
        drive(1'b1, 8'h50, acc, n);
        vld = 1'b0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 8'h51 + 8'(i), acc, e);
            n_tests++;
            if (acc !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_accept%0d: got rdy %b, need 1", i, acc);
            end
        end
        refusals = 0;
        for (int i = 0; i < 30; i++) begin
            drive(1'b1, 8'h55, acc, e);
            if (acc) break;
            refusals++;
        end
        vld = 1'b0;
        n_tests++;
        if (acc !== 1'b1 || refusals !== 9) begin
            n_fail++;
            $display("FAIL b2b_full: got accepted=%b after %0d refusals, need 1 after 9", acc, refusals);
        end
        wait_idle("b2b_idle", 300);
        n_tests++;
        if (rise_bus.size() != 6) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d pulses, need 6", rise_bus.size());
        end
        for (int i = 0; i < 6 && i < rise_bus.size(); i++) begin
            n_tests++;
            if (rise_bus[i] !== {1'b1, 8'h50 + 8'(i)}) begin
                n_fail++;
                $display("FAIL b2b_order%0d: got %h, need %h", i, rise_bus[i], {1'b1, 8'h50 + 8'(i)});
            end
            if (i > 0) begin
                n_tests++;
                if (rise_cyc[i] - rise_cyc[i-1] !== 13) begin
                    n_fail++;
                    $display("FAIL b2b_gap%0d: got %0d, need 13", i, rise_cyc[i] - rise_cyc[i-1]);
                end
            end
        end
    endtask

    task automatic test_pwr_push();
        bit acc;
        int e;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        clear_mon();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h61 + 8'(i), acc, e);
            n_tests++;
            if (acc !== 1'b1 || o_init_done !== 1'b0) begin
                n_fail++;
                $display("FAIL pwr_accept%0d: got rdy=%b done=%b, need 1 0", i, acc, o_init_done);
            end
        end
        vld = 1'b0;
        wait_done("pwr_done", 300);
        wait_idle("pwr_idle", 200);
        check_init_log("pwr_init", rel_cyc);
        n_tests++;
        if (rise_bus.size() != 9) begin
            n_fail++;
            $display("FAIL pwr_count: got %0d pulses, need 9", rise_bus.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if (rise_bus[6+i] !== {1'b1, 8'h61 + 8'(i)}) begin
                    n_fail++;
                    $display("FAIL pwr_byte%0d: got %h, need %h", i, rise_bus[6+i], {1'b1, 8'h61 + 8'(i)});
                end
            end
            n_tests++;
            if (rise_cyc[6] - rise_cyc[5] !== 14) begin
                n_fail++;
                $display("FAIL pwr_gap: got %0d, need 14", rise_cyc[6] - rise_cyc[5]);
            end
        end
    endtask

    task automatic test_reset_mid();
        bit acc;
        int e, k;
        @(negedge clk);
        clear_mon();
        drive(1'b1, 8'h71, acc, e);
        drive(1'b1, 8'h72, acc, e);
        drive(1'b1, 8'h73, acc, e);
        vld = 1'b0;
        for (k = 0; k < 20; k++) begin
            if (o_lcd_en === 1'b1) break;
            @(negedge clk);
        end
        n_tests++;
        if (o_lcd_en !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_en_high: got %b within 20 cycles, need 1", o_lcd_en);
        end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_lcd_en, o_lcd_rs, o_lcd_data, o_init_done, o_busy, o_rdy} !== {1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_async: got en=%b rs=%b data=%h done=%b busy=%b rdy=%b, need 0 0 00 0 1 1",
                     o_lcd_en, o_lcd_rs, o_lcd_data, o_init_done, o_busy, o_rdy);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        rel_cyc = cyc;
        clear_mon();
        wait_done("mid_done", 300);
        repeat (40) @(negedge clk);
        check_init_log("mid_init", rel_cyc);
        n_tests++;
        if (rise_bus.size() != 6 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_lost: got %0d pulses busy=%b, need 6 pulses busy=0", rise_bus.size(), o_busy);
        end
        n_tests++;
        if (rw_bad !== 1'b0 || stable_bad !== 1'b0) begin
            n_fail++;
            $display("FAIL rw_and_stability: got rw_bad=%b stable_bad=%b, need 0 0", rw_bad, stable_bad);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_clear_gap();
        test_back_to_back();
        test_pwr_push();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
